// File: rtl/spi_pkg.sv
// Shared SPI definitions: opcodes, frame widths and the FSM state encoding.
// The slave reuses the state encoding to decode waveforms.
package spi_pkg;

  localparam int FRAME_W = 10;
  localparam int RD_W    = 8;
  localparam int CNT_W   = 4;

  localparam logic [1:0] OP_WR_ADDR = 2'b00;
  localparam logic [1:0] OP_WR_DATA = 2'b01;
  localparam logic [1:0] OP_RD_ADDR = 2'b10;
  localparam logic [1:0] OP_RD_DATA = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SELECT = 3'd1,
    ST_CMD    = 3'd2,
    ST_SHIFT  = 3'd3,
    ST_TURN   = 3'd4,
    ST_RECV   = 3'd5,
    ST_END    = 3'd6
  } spi_state_e;

  function automatic logic op_is_rd_data(input logic [1:0] op);
    return op == OP_RD_DATA;
  endfunction

endpackage

// File: rtl/spi_master_shifter.sv
// TX parallel-load shifter (MSB out first) and RX serial-in shifter.
// Enables are decoded by the spi_master FSM.
module spi_master_shifter
  import spi_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load_en,
  input  logic [FRAME_W-1:0] load_data,
  input  logic               shift_en,
  input  logic               capture_en,
  input  logic               miso,
  output logic               tx_msb,
  output logic [RD_W-1:0]    rx_data
);

  logic [FRAME_W-1:0] tx_q, tx_d;
  logic [RD_W-1:0]    rx_q, rx_d;

  always_comb begin
    tx_d = tx_q;
    rx_d = rx_q;
    if (load_en) begin
      tx_d = load_data;
    end else if (shift_en) begin
      tx_d = {tx_q[FRAME_W-2:0], 1'b0};
    end
    if (capture_en) begin
      rx_d = {rx_q[RD_W-2:0], miso};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx_q <= '0;
      rx_q <= '0;
    end else begin
      tx_q <= tx_d;
      rx_q <= rx_d;
    end
  end

  assign tx_msb  = tx_q[FRAME_W-1];
  assign rx_data = rx_q;

endmodule

// File: rtl/spi_master.sv
// SPI master for the 10-bit-frame slave; optional sticky overrun flag
// enabled by defining SPI_MASTER_OVERRUN_EN.
module spi_master
  import spi_pkg::*;
#(
  parameter int unsigned TURNAROUND = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [FRAME_W-1:0] cmd_data,
  input  logic               MISO,
  output logic               SS_n,
  output logic               MOSI,
  output logic               busy,
  output logic               done,
  output logic [RD_W-1:0]    rd_data,
  output logic               rd_valid,
  output logic               overrun
);

  if (TURNAROUND < 1 || TURNAROUND > 15) begin : g_bad_turn
    $error("TURNAROUND must be 1..15");
  end

  localparam logic [CNT_W-1:0] SHIFT_LAST = CNT_W'(FRAME_W - 1);
  localparam logic [CNT_W-1:0] TURN_LAST  = CNT_W'(TURNAROUND - 1);
  localparam logic [CNT_W-1:0] RECV_LAST  = CNT_W'(RD_W - 1);

  spi_state_e         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               rd_q, rd_d;
  logic               ss_n_q, ss_n_d;
  logic               mosi_q, mosi_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               rd_valid_q, rd_valid_d;
  logic [RD_W-1:0]    rd_data_q, rd_data_d;

  logic               load_en;
  logic               shift_en;
  logic               capture_en;
  logic               tx_msb;
  logic [RD_W-1:0]    rx_data;

  spi_master_shifter u_shifter (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_en    (load_en),
    .load_data  (cmd_data),
    .shift_en   (shift_en),
    .capture_en (capture_en),
    .miso       (MISO),
    .tx_msb     (tx_msb),
    .rx_data    (rx_data)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rd_d    = rd_q;
    load_en = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_SELECT;
          load_en = 1'b1;
          rd_d    = op_is_rd_data(cmd_data[9:8]);
        end
      end
      ST_SELECT: state_d = ST_CMD;
      ST_CMD: begin
        state_d = ST_SHIFT;
        cnt_d   = '0;
      end
      ST_SHIFT: begin
        if (cnt_q == SHIFT_LAST) begin
          cnt_d   = '0;
          state_d = rd_q ? ST_TURN : ST_END;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_TURN: begin
        if (cnt_q == TURN_LAST) begin
          cnt_d   = '0;
          state_d = ST_RECV;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RECV: begin
        if (cnt_q == RECV_LAST) begin
          state_d = ST_END;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_END:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they change on the
  // same edge as the state register.
  always_comb begin
    shift_en   = state_d == ST_SHIFT;
    capture_en = state_d == ST_RECV;
    ss_n_d     = (state_d == ST_IDLE) || (state_d == ST_END);
    mosi_d     = 1'b0;
    if ((state_d == ST_CMD) || (state_d == ST_SHIFT)) begin
      mosi_d = tx_msb;
    end
    busy_d     = state_d != ST_IDLE;
    done_d     = state_d == ST_END;
    rd_valid_d = (state_d == ST_END) && rd_q;
    rd_data_d  = rd_valid_d ? rx_data : rd_data_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      rd_q       <= 1'b0;
      ss_n_q     <= 1'b1;
      mosi_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rd_q       <= rd_d;
      ss_n_q     <= ss_n_d;
      mosi_q     <= mosi_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
    end
  end

`ifdef SPI_MASTER_OVERRUN_EN
  logic overrun_q, overrun_d;

  always_comb begin
    overrun_d = overrun_q | (start && (state_q != ST_IDLE));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      overrun_q <= 1'b0;
    end else begin
      overrun_q <= overrun_d;
    end
  end

  assign overrun = overrun_q;
`else
  assign overrun = 1'b0;
`endif

  assign SS_n     = ss_n_q;
  assign MOSI     = mosi_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;

endmodule

// File: tb/tb_spi_master.sv
// Scoreboard bench for spi_master: stimulus pushes expected frames,
// a negedge monitor pops and compares on each done pulse.
module tb_spi_master;

  localparam int T = 2;

`ifdef SPI_MASTER_OVERRUN_EN
  localparam logic OVR_EXP = 1'b1;
`else
  localparam logic OVR_EXP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [9:0] cmd_data;
  logic       MISO;
  logic       SS_n;
  logic       MOSI;
  logic       busy;
  logic       done;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       overrun;

  spi_master #(.TURNAROUND(T)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .cmd_data (cmd_data),
    .MISO     (MISO),
    .SS_n     (SS_n),
    .MOSI     (MOSI),
    .busy     (busy),
    .done     (done),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .overrun  (overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [10:0] mosi;
    int          low;
    logic        rv;
    logic [7:0]  rdata;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Slave-side MISO model: bit 7 first, sampled at edges k+12+T..k+19+T.
  int         mn = 0;
  logic [7:0] miso_byte = 8'h00;
  always @(negedge clk) begin
    if (SS_n == 1'b0) mn++;
    else mn = 0;
    if (mn >= 12 + T && mn <= 19 + T) MISO = miso_byte[19 + T - mn];
    else MISO = 1'b1;
  end

  // Monitor
  logic        prev_ss = 1'b1;
  logic        prev_done = 1'b0;
  logic        post_done = 1'b0;
  int          low = 0;
  logic [10:0] mosi_bits = '0;
  logic        extra = 1'b0;
  int          cyc = 0;
  int          last_done_cyc = -100;
  int          n_frames = 0;

  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (post_done) begin
      chk("busy_fall", busy, 0);
      post_done = 1'b0;
    end
    if (SS_n == 1'b0) begin
      if (prev_ss) begin
        low = 1;
        mosi_bits = '0;
        extra = 1'b0;
        n_frames++;
        chk("gap_after_done", (cyc - last_done_cyc) >= 2, 1);
        chk("busy_rise", busy, 1);
      end else begin
        low++;
      end
      if (low >= 2 && low <= 12) mosi_bits[12 - low] = MOSI;
      else if (MOSI) extra = 1'b1;
    end
    if (rd_valid) chk("rv_with_done", done, 1);
    if (done) begin
      chk("done_single", prev_done, 0);
      chk("ss_high_at_done", SS_n, 1);
      chk("busy_at_done", busy, 1);
      chk("sb_nonempty", sb.size() != 0, 1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("mosi_seq", mosi_bits, e.mosi);
        chk("ss_low_cycles", low, e.low);
        chk("mosi_idle_zero", extra, 0);
        chk("rd_valid", rd_valid, e.rv);
        if (e.rv) chk("rd_data", rd_data, e.rdata);
      end
      last_done_cyc = cyc;
      post_done = 1'b1;
    end
    prev_ss = SS_n;
    prev_done = done;
  end

  function automatic exp_t mk_exp(input logic [9:0] cmd,
                                  input logic [7:0] rx);
    exp_t e;
    e.mosi  = {cmd[9], cmd};
    e.rv    = cmd[9:8] == 2'b11;
    e.low   = e.rv ? 20 + T : 12;
    e.rdata = rx;
    return e;
  endfunction

  // Returns #1 after the accepting edge k.
  task automatic accept(input logic [9:0] cmd);
    int n = 0;
    start = 1'b1;
    cmd_data = cmd;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!busy && n < 40);
    chk("accept", busy, 1);
    start = 1'b0;
    cmd_data = ~cmd;
  endtask

  task automatic issue(input logic [9:0] cmd, input logic [7:0] rx);
    sb.push_back(mk_exp(cmd, rx));
    miso_byte = rx;
    accept(cmd);
  endtask

  task automatic wait_done();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < 100);
    chk("done_seen", done, 1);
  endtask

  initial begin
    int dn;
    int nf;
    rst_n = 1'b0;
    start = 1'b0;
    cmd_data = '0;
    MISO = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ss_n", SS_n, 1);
    chk("rst_mosi", MOSI, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_rd_data", rd_data, 8'h00);
    chk("rst_overrun", overrun, 0);

    issue(10'h0A5, 8'h00);
    wait_done();

    sb.push_back(mk_exp(10'h13C, 8'h00));
    sb.push_back(mk_exp(10'h13C, 8'h00));
    start = 1'b1;
    cmd_data = 10'h13C;
    wait_done();
    wait_done();
    start = 1'b0;

    issue(10'h210, 8'h00);
    wait_done();

    issue(10'h300, 8'hC3);
    wait_done();
    issue(10'h381, 8'h5A);
    wait_done();
    @(negedge clk);
    chk("rd_data_hold", rd_data, 8'h5A);

    // Reset sampled at k+6 of a write frame.
    accept(10'h155);
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("abort_ss_n", SS_n, 1);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_rd_data", rd_data, 8'h00);
    rst_n = 1'b1;
    dn = 0;
    repeat (20) begin
      @(negedge clk);
      if (done) dn++;
    end
    chk("abort_no_done", dn, 0);
    issue(10'h2A7, 8'h00);
    wait_done();

    // Start pulsed again at k+5 must be dropped.
    sb.push_back(mk_exp(10'h1FF, 8'h00));
    accept(10'h1FF);
    repeat (4) @(posedge clk);
    #1 start = 1'b1;
    cmd_data = 10'h300;
    @(posedge clk);
    #1 start = 1'b0;
    chk("overrun_set", overrun, OVR_EXP);
    wait_done();
    nf = n_frames;
    repeat (20) @(negedge clk);
    chk("no_second_frame", n_frames, nf);
    chk("overrun_sticky", overrun, OVR_EXP);

    chk("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
